// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state for the trailing checksum byte.
package imem_loader_pkg;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK  = 3'd4,
`endif
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted stream bytes into 32-bit words; word_valid pulses the cycle after the 4th byte.
import imem_loader_pkg::*;

module imem_word_packer #(
    parameter int LITTLE_END = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_last,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]  cnt;
    logic [23:0] sh;
    logic [23:0] sh_nxt;
    logic [31:0] packed_word;

    assign byte_last = (cnt == 2'(WORD_BYTES - 1));

    // Little-endian shifts new bytes in from the top so the first byte ends up in [7:0].
    assign sh_nxt      = (LITTLE_END != 0) ? {byte_data, sh[23:8]} : {sh[15:0], byte_data};
    assign packed_word = (LITTLE_END != 0) ? {byte_data, sh}       : {sh, byte_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            sh         <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (byte_valid) begin
                cnt <= cnt + 2'd1;
                if (byte_last) begin
                    word_valid <= 1'b1;
                    word       <= packed_word;
                end else begin
                    sh <= sh_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory and holds the core in reset until done.
// Optional trailing XOR checksum when IMEM_LOADER_CHECKSUM_EN is defined.
import imem_loader_pkg::*;

module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int LITTLE_END = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WORD_W-1:0]     wr_data,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            dbg_state
);

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t ST_TAIL = ST_CHECK;
`else
    localparam loader_state_t ST_TAIL = ST_DONE;
`endif

    loader_state_t state, state_nxt;
    logic          accept, start_ok, data_accept, byte_last, last_word;
    logic [7:0]    len_hi;
    logic [15:0]   len_q, len_n;
    logic [16:0]   word_idx;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    chk_q;
`endif

    // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready; the source
    // holds rx_data stable while rx_valid is high, and a low rx_valid simply stalls the loader.
    assign accept      = rx_valid && rx_ready;
    assign start_ok    = start && (state inside {ST_IDLE, ST_DONE, ST_ERR});
    assign data_accept = accept && (state == ST_DATA);
    assign len_n       = {len_hi, rx_data};
    assign last_word   = ((word_idx + 17'd1) == {1'b0, len_q});
    assign dbg_state   = state;

    imem_word_packer #(.LITTLE_END(LITTLE_END)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_valid (data_accept),
        .byte_data  (rx_data),
        .byte_last  (byte_last),
        .word_valid (wr_en),
        .word       (wr_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_nxt = ST_LEN_HI;
            ST_LEN_HI: if (accept) state_nxt = ST_LEN_LO;
            ST_LEN_LO: begin
                // 17-bit compare so a full-depth image (N == DEPTH) is legal.
                if (accept) begin
                    if ({1'b0, len_n} > DEPTH) state_nxt = ST_ERR;
                    else if (len_n == 16'd0)   state_nxt = ST_TAIL;
                    else                       state_nxt = ST_DATA;
                end
            end
            ST_DATA: if (data_accept && byte_last && last_word) state_nxt = ST_TAIL;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: if (accept) state_nxt = (rx_data == chk_q) ? ST_DONE : ST_ERR;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_rst_n = 1'b0;
        case (state)
            ST_LEN_HI, ST_LEN_LO, ST_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            ST_DONE: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
            end
            ST_ERR:  error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_hi   <= '0;
            len_q    <= '0;
            word_idx <= '0;
            wr_addr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q    <= '0;
`endif
        end else begin
            if (start_ok) begin
                word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                chk_q    <= '0;
`endif
            end
            if (accept && (state == ST_LEN_HI)) len_hi <= rx_data;
            if (accept && (state == ST_LEN_LO)) len_q  <= len_n;
            if (data_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                chk_q <= chk_q ^ rx_data;
`endif
                // wr_addr lines up with the packer's registered word on the following cycle.
                if (byte_last) begin
                    wr_addr  <= word_idx[ADDR_WIDTH-1:0];
                    word_idx <= word_idx + 17'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a big-endian ADDR_WIDTH=4 instance and a little-endian ADDR_WIDTH=8 instance
// share one byte stream; writes are checked against a frame-level reference model.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic       rx_ready_a, wr_en_a, cpu_rst_n_a, busy_a, done_a, error_a;
    logic [3:0] wr_addr_a;
    logic [31:0] wr_data_a;
    logic [2:0] dbg_state_a;
    logic       rx_ready_b, wr_en_b, cpu_rst_n_b, busy_b, done_b, error_b;
    logic [7:0] wr_addr_b;
    logic [31:0] wr_data_b;
    logic [2:0] dbg_state_b;

    int checks = 0;
    int errors = 0;

    logic [39:0] exp_a[$], exp_b[$], act_a[$], act_b[$];
    logic [7:0]  data_q[$], frame_q[$];
    logic        exp_done_a, exp_done_b;

    imem_loader #(.ADDR_WIDTH(4), .LITTLE_END(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .cpu_rst_n(cpu_rst_n_a), .busy(busy_a), .done(done_a), .error(error_a),
        .dbg_state(dbg_state_a)
    );

    imem_loader #(.ADDR_WIDTH(8), .LITTLE_END(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .cpu_rst_n(cpu_rst_n_b), .busy(busy_b), .done(done_b), .error(error_b),
        .dbg_state(dbg_state_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && wr_en_a) act_a.push_back({4'h0, wr_addr_a, wr_data_a});
        if (rst && wr_en_b) act_b.push_back({wr_addr_b, wr_data_b});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks (entered and left on a falling edge) ----------------
    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int t;
        t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready_a && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready_a) begin
            checks++;
            errors++;
            $display("FAIL send_byte: rx_ready got 0 required 1 within 50 cycles");
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    endtask

    task automatic send_frame(input int max_gap);
        foreach (frame_q[i]) send_byte(frame_q[i], max_gap);
    endtask

    // ---------------- reference model ----------------
    task automatic rand_data(input int n);
        data_q.delete();
        for (int i = 0; i < 4 * n; i++) data_q.push_back(8'($urandom));
    endtask

    task automatic make_frame(input int n, input bit good_chk);
        logic [7:0] x;
        frame_q.delete();
        frame_q.push_back(8'(n >> 8));
        frame_q.push_back(8'(n));
        foreach (data_q[i]) frame_q.push_back(data_q[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = 8'h00;
        foreach (data_q[i]) x = x ^ data_q[i];
        frame_q.push_back(good_chk ? x : (x ^ 8'h01));
`else
        x = {7'h0, good_chk};
`endif
    endtask

    // Image of N words fits a memory of depth D iff N <= D; the first stream byte of each word
    // is the most significant (instance a) or least significant (instance b) byte.
    task automatic model_expect(input int n, input bit good_chk);
        logic [31:0] w_be, w_le;
        exp_a.delete();
        exp_b.delete();
        for (int i = 0; i < n; i++) begin
            w_be = (32'(data_q[4*i]) << 24) + (32'(data_q[4*i+1]) << 16)
                 + (32'(data_q[4*i+2]) << 8) + 32'(data_q[4*i+3]);
            w_le = (32'(data_q[4*i+3]) << 24) + (32'(data_q[4*i+2]) << 16)
                 + (32'(data_q[4*i+1]) << 8) + 32'(data_q[4*i]);
            if (n <= 16)  exp_a.push_back({8'(i), w_be});
            if (n <= 256) exp_b.push_back({8'(i), w_le});
        end
        exp_done_a = (n <= 16) && good_chk;
        exp_done_b = (n <= 256) && good_chk;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_ready_a, wr_en_a, cpu_rst_n_a, busy_a, done_a, error_a, wr_addr_a, wr_data_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: got ready/wr/cpu/busy/done/err=%b%b%b%b%b%b addr=%h data=%h required all zero",
                     rx_ready_a, wr_en_a, cpu_rst_n_a, busy_a, done_a, error_a, wr_addr_a, wr_data_a);
        end
        checks++;
        if ({rx_ready_b, wr_en_b, cpu_rst_n_b, busy_b, done_b, error_b, wr_addr_b, wr_data_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: got ready/wr/cpu/busy/done/err=%b%b%b%b%b%b addr=%h data=%h required all zero",
                     rx_ready_b, wr_en_b, cpu_rst_n_b, busy_b, done_b, error_b, wr_addr_b, wr_data_b);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_spec_frame;
        act_a.delete();
        act_b.delete();
        data_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        make_frame(2, 1'b1);
        exp_a = '{40'h00_2008_0005, 40'h01_AC08_0000};
        exp_b = '{40'h00_0500_0820, 40'h01_0000_08AC};
        pulse_start();
        send_frame(0);
        repeat (3) @(negedge clk);
        checks++;
        if (act_a.size() != 2 || act_b.size() != 2) begin
            errors++;
            $display("FAIL spec_frame count: got %0d/%0d writes required 2/2", act_a.size(), act_b.size());
        end else begin
            foreach (exp_a[i]) begin
                checks++;
                if (act_a[i] !== exp_a[i]) begin
                    errors++;
                    $display("FAIL spec_frame be[%0d]: got %h required %h", i, act_a[i], exp_a[i]);
                end
                checks++;
                if (act_b[i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL spec_frame le[%0d]: got %h required %h", i, act_b[i], exp_b[i]);
                end
            end
        end
        checks++;
        if ({done_a, cpu_rst_n_a, busy_a, error_a, done_b, cpu_rst_n_b} !== 6'b110011) begin
            errors++;
            $display("FAIL spec_frame status: got done/cpu/busy/err/done_b/cpu_b=%b%b%b%b%b%b required 110011",
                     done_a, cpu_rst_n_a, busy_a, error_a, done_b, cpu_rst_n_b);
        end
    endtask

    task automatic test_zero_len;
        act_a.delete();
        act_b.delete();
        data_q.delete();
        make_frame(0, 1'b1);
        pulse_start();
        send_frame(0);
        checks++;
        if (done_a !== 1'b1 || cpu_rst_n_a !== 1'b1 || done_b !== 1'b1) begin
            errors++;
            $display("FAIL zero_len done: got done=%b cpu_rst_n=%b done_b=%b required 1 1 1", done_a, cpu_rst_n_a, done_b);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (act_a.size() != 0 || act_b.size() != 0) begin
            errors++;
            $display("FAIL zero_len writes: got %0d/%0d required 0/0", act_a.size(), act_b.size());
        end
    endtask

    task automatic test_len_error;
        act_a.delete();
        act_b.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        repeat (3) @(negedge clk);
        checks++;
        if ({error_a, done_a, cpu_rst_n_a, busy_a, rx_ready_a} !== 5'b10000) begin
            errors++;
            $display("FAIL len_error status: got err/done/cpu/busy/ready=%b%b%b%b%b required 10000",
                     error_a, done_a, cpu_rst_n_a, busy_a, rx_ready_a);
        end
        checks++;
        if (act_a.size() != 0) begin
            errors++;
            $display("FAIL len_error writes: got %0d required 0", act_a.size());
        end
        checks++;
        if (busy_b !== 1'b1 || error_b !== 1'b0) begin
            errors++;
            $display("FAIL len_error depth256: got busy=%b error=%b required 1 0", busy_b, error_b);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load;
        act_a.delete();
        act_b.delete();
        data_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        make_frame(2, 1'b1);
        model_expect(2, 1'b1);
        // The first word is written before the reset and again by the reload.
        exp_a.push_front(exp_a[0]);
        exp_b.push_front(exp_b[0]);
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(frame_q[i], 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({rx_ready_a, wr_en_a, cpu_rst_n_a, busy_a, done_a, error_a, wr_addr_a, wr_data_a} !== '0) begin
            errors++;
            $display("FAIL mid_reset outputs: got ready/wr/cpu/busy/done/err=%b%b%b%b%b%b addr=%h data=%h required all zero",
                     rx_ready_a, wr_en_a, cpu_rst_n_a, busy_a, done_a, error_a, wr_addr_a, wr_data_a);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse_start();
        send_frame(1);
        repeat (3) @(negedge clk);
        checks++;
        if (act_a.size() != exp_a.size() || act_b.size() != exp_b.size()) begin
            errors++;
            $display("FAIL mid_reset count: got %0d/%0d required %0d/%0d",
                     act_a.size(), act_b.size(), exp_a.size(), exp_b.size());
        end else begin
            foreach (exp_a[i]) begin
                checks++;
                if (act_a[i] !== exp_a[i] || act_b[i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL mid_reset word[%0d]: got %h/%h required %h/%h",
                             i, act_a[i], act_b[i], exp_a[i], exp_b[i]);
                end
            end
        end
        checks++;
        if (done_a !== 1'b1 || cpu_rst_n_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset done: got done=%b cpu_rst_n=%b required 1 1", done_a, cpu_rst_n_a);
        end
    endtask

    task automatic test_start_ignored;
        act_a.delete();
        act_b.delete();
        rand_data(3);
        make_frame(3, 1'b1);
        model_expect(3, 1'b1);
        pulse_start();
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], 0);
            if (i == 5) pulse_start();
        end
        repeat (3) @(negedge clk);
        checks++;
        if (act_a.size() != exp_a.size()) begin
            errors++;
            $display("FAIL start_ignored count: got %0d required %0d", act_a.size(), exp_a.size());
        end else begin
            foreach (exp_a[i]) begin
                checks++;
                if (act_a[i] !== exp_a[i]) begin
                    errors++;
                    $display("FAIL start_ignored word[%0d]: got %h required %h", i, act_a[i], exp_a[i]);
                end
            end
        end
        checks++;
        if (done_a !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored done: got %b required 1", done_a);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        for (int f = 0; f < 6; f++) begin
            act_a.delete();
            act_b.delete();
            n = $urandom_range(16, 1);
            rand_data(n);
            make_frame(n, 1'b1);
            model_expect(n, 1'b1);
            pulse_start();
            checks++;
            if (busy_a !== 1'b1 || done_a !== 1'b0 || cpu_rst_n_a !== 1'b0) begin
                errors++;
                $display("FAIL restart status: got busy=%b done=%b cpu_rst_n=%b required 1 0 0", busy_a, done_a, cpu_rst_n_a);
            end
            send_frame((f % 2 == 0) ? 0 : 2);
            repeat (3) @(negedge clk);
            checks++;
            if (act_a.size() != exp_a.size() || act_b.size() != exp_b.size()) begin
                errors++;
                $display("FAIL random n=%0d count: got %0d/%0d required %0d/%0d",
                         n, act_a.size(), act_b.size(), exp_a.size(), exp_b.size());
            end else begin
                foreach (exp_a[i]) begin
                    checks++;
                    if (act_a[i] !== exp_a[i] || act_b[i] !== exp_b[i]) begin
                        errors++;
                        $display("FAIL random n=%0d word[%0d]: got %h/%h required %h/%h",
                                 n, i, act_a[i], act_b[i], exp_a[i], exp_b[i]);
                    end
                end
            end
            checks++;
            if (done_a !== exp_done_a || done_b !== exp_done_b || cpu_rst_n_a !== exp_done_a) begin
                errors++;
                $display("FAIL random n=%0d status: got done=%b/%b cpu_rst_n=%b required %b/%b %b",
                         n, done_a, done_b, cpu_rst_n_a, exp_done_a, exp_done_b, exp_done_a);
            end
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        for (int k = 0; k < 2; k++) begin
            act_a.delete();
            act_b.delete();
            data_q = '{8'h12, 8'h34, 8'h56, 8'h78};
            make_frame(1, k == 0);
            model_expect(1, k == 0);
            pulse_start();
            send_frame(0);
            repeat (3) @(negedge clk);
            checks++;
            if (done_a !== exp_done_a || error_a !== !exp_done_a || cpu_rst_n_a !== exp_done_a) begin
                errors++;
                $display("FAIL checksum k=%0d: got done=%b error=%b cpu_rst_n=%b required %b %b %b",
                         k, done_a, error_a, cpu_rst_n_a, exp_done_a, !exp_done_a, exp_done_a);
            end
            checks++;
            if (act_a.size() != 1 || act_a[0] !== exp_a[0]) begin
                errors++;
                $display("FAIL checksum k=%0d word: got %0d writes required 1 of %h", k, act_a.size(), exp_a[0]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_spec_frame();
        test_zero_len();
        test_len_error();
        test_reset_mid_load();
        test_start_ignored();
        test_back_to_back();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
